// File: rtl/htif_pkg.sv
// Shared definitions for the HTIF byte-serial protocol (host driver and target bridge).
package htif_pkg;

    localparam logic [7:0] HTIF_CMD_ADDR   = 8'h61;  // "a"
    localparam logic [7:0] HTIF_CMD_READ   = 8'h72;  // "r"
    localparam logic [7:0] HTIF_CMD_WRITE  = 8'h77;  // "w"
    localparam logic [7:0] HTIF_CMD_READ2  = 8'h52;  // "R"
    localparam logic [7:0] HTIF_CMD_WRITE2 = 8'h57;  // "W"

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StSendAcmd = 4'd1,
        StSendAddr = 4'd2,
        StSendCmd  = 4'd3,
        StSendData = 4'd4,
        StRecvData = 4'd5
    } htif_host_state_e;

    // Little-endian byte lane select.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/htif_host.sv
// HTIF host driver: serializes word read/write requests into command/address/data bytes
// and reassembles read-response bytes into a word.
module htif_host
    import htif_pkg::*;
#(
    parameter bit SKIP_ADDR = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        rx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [3:0]  s
);

    htif_host_state_e r_state;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_asm;
    logic [31:0]      r_shadow_addr;
    logic             r_shadow_valid;
    logic [1:0]       r_cnt;
    logic             r_req_ready;
    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             r_rx_ready;

    logic             w_req_go;
    logic             w_tx_done;
    logic             w_rx_go;
    logic             w_skip;
    logic             w_in_send;
    logic [7:0]       w_tx_byte;

    assign w_req_go  = req_valid & r_req_ready;
    assign w_tx_done = r_tx_valid & tx_ready;
    assign w_rx_go   = rx_valid & r_rx_ready;
    assign w_skip    = SKIP_ADDR && r_shadow_valid && (req_address == r_shadow_addr);
    assign w_in_send = (r_state == StSendAcmd) || (r_state == StSendAddr) ||
                       (r_state == StSendCmd)  || (r_state == StSendData);

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            StSendAcmd: w_tx_byte = HTIF_CMD_ADDR;
            StSendAddr: w_tx_byte = word_byte(r_addr, r_cnt);
            StSendCmd:  w_tx_byte = r_write ? HTIF_CMD_WRITE : HTIF_CMD_READ;
            StSendData: w_tx_byte = word_byte(r_wdata, r_cnt);
            default:    w_tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_write        <= 1'b0;
            r_addr         <= 32'h0;
            r_wdata        <= 32'h0;
            r_asm          <= 32'h0;
            r_shadow_addr  <= 32'h0;
            r_shadow_valid <= 1'b0;
            r_cnt          <= 2'd0;
            r_req_ready    <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_data     <= 32'h0;
            r_tx_valid     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_rx_ready     <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;

            // A byte is offered one cycle, withdrawn the cycle after acceptance.
            if (w_in_send && !r_tx_valid) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_tx_byte;
            end
            if (w_tx_done) begin
                r_tx_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_req_go) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_addr      <= req_address;
                        r_wdata     <= req_data;
                        r_cnt       <= 2'd0;
                        r_state     <= w_skip ? StSendCmd : StSendAcmd;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                StSendAcmd: begin
                    if (w_tx_done) begin
                        r_cnt   <= 2'd0;
                        r_state <= StSendAddr;
                    end
                end
                StSendAddr: begin
                    if (w_tx_done) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_shadow_addr  <= r_addr;
                            r_shadow_valid <= 1'b1;
                            r_state        <= StSendCmd;
                        end
                    end
                end
                StSendCmd: begin
                    if (w_tx_done) begin
                        r_cnt <= 2'd0;
                        if (r_write) begin
                            r_state <= StSendData;
                        end else begin
                            r_rx_ready <= 1'b1;
                            r_state    <= StRecvData;
                        end
                    end
                end
                StSendData: begin
                    if (w_tx_done) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_shadow_addr <= r_shadow_addr + 32'd4;
                            r_req_ready   <= 1'b1;
                            r_state       <= StIdle;
                        end
                    end
                end
                StRecvData: begin
                    if (w_rx_go) begin
                        r_asm[{r_cnt, 3'b000} +: 8] <= rx_data;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_res_data    <= {rx_data, r_asm[23:0]};
                            r_res_valid   <= 1'b1;
                            r_rx_ready    <= 1'b0;
                            r_shadow_addr <= r_shadow_addr + 32'd4;
                            r_req_ready   <= 1'b1;
                            r_state       <= StIdle;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign rx_ready  = r_rx_ready;
    assign s         = r_state;

endmodule

// File: tb/tb_htif_host.sv
// Directed bench for htif_host: byte streams, read reassembly, stalls, reset abort, address wrap.
module tb_htif_host;
    import htif_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_address, req_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic        tx_ready, tx_valid;
    logic [7:0]  tx_data;
    logic        rx_ready, rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  s;

    htif_host #(.SKIP_ADDR(1'b1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_address (req_address),
        .req_data    (req_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .rx_ready    (rx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .s           (s)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    int          res_cnt = 0;
    logic [31:0] last_res = 32'h0;
    bit          rnd = 1'b0;
    bit          pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Link partner: drives tx_ready/rx bytes at negedge, records handshakes before posedge.
    initial begin
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clock);
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_valid = (rx_q.size() > 0) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            #1;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                    chk("tx_hold_data", {24'd0, tx_data}, {24'd0, pend_data});
                end
                pend      = tx_valid && !tx_ready;
                pend_data = tx_data;
                if (tx_valid && tx_ready) txq.push_back(tx_data);
                if (rx_valid && rx_ready) void'(rx_q.pop_front());
                if (res_valid) begin
                    res_cnt++;
                    last_res = res_data;
                end
            end
        end
    end

    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        int t;
        @(negedge clock);
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_data    = d;
        #1;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int want_res);
        int t;
        txq.delete();
        issue(tag, w, a, d);
        t = 0;
        while (!(req_ready && txq.size() >= exp_tx.size() && res_cnt >= want_res) && t < 3000)
        begin
            @(negedge clock);
            #1;
            t++;
        end
        chk({tag, "_done"}, {31'd0, t < 3000}, 32'd1);
        chk({tag, "_ntx"}, txq.size(), exp_tx.size());
        foreach (exp_tx[i]) begin
            chk({tag, "_byte"}, (i < txq.size()) ? {24'd0, txq[i]} : 32'hFFFF_FFFF,
                {24'd0, exp_tx[i]});
        end
    endtask

    initial begin
        int base;
        int t;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = 32'h0;
        req_data    = 32'h0;

        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_state", {28'd0, s}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        exp_tx = '{8'h61, 8'h00, 8'h10, 8'h00, 8'h00, 8'h77, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        txn("wr_addr", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0);

        exp_tx = '{8'h77, 8'h04, 8'h03, 8'h02, 8'h01};
        txn("wr_skip", 1'b1, 32'h0000_1004, 32'h0102_0304, 0);

        base = res_cnt;
        rx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        exp_tx = '{8'h72};
        txn("rd_skip", 1'b0, 32'h0000_1008, 32'h0, base + 1);
        chk("rd_skip_data", last_res, 32'h1234_5678);
        repeat (4) @(negedge clock);
        #1;
        chk("rd_skip_pulses", res_cnt, base + 1);
        chk("rd_hold_data", res_data, 32'h1234_5678);
        chk("rd_hold_valid", {31'd0, res_valid}, 32'd0);

        rnd = 1'b1;
        base = res_cnt;
        rx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_tx = '{8'h61, 8'h00, 8'h20, 8'h00, 8'h00, 8'h72};
        txn("rd_stall", 1'b0, 32'h0000_2000, 32'h0, base + 1);
        chk("rd_stall_data", last_res, 32'hDDCC_BBAA);
        chk("rd_stall_pulses", res_cnt, base + 1);
        rnd = 1'b0;

        // Abort a read with only two response bytes delivered.
        base = res_cnt;
        rx_q = '{8'h11, 8'h22};
        issue("rd_abort", 1'b0, 32'h0000_2004, 32'h0);
        t = 0;
        while (rx_q.size() > 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        repeat (4) @(negedge clock);
        #1;
        chk("abort_in_recv", {28'd0, s}, {28'd0, StRecvData});
        chk("abort_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rx_zero", {31'd0, rx_ready}, 32'd0);
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_res_data", res_data, 32'd0);
        chk("abort_state", {28'd0, s}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        rx_q.delete();
        rx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_tx = '{8'h61, 8'h08, 8'h10, 8'h00, 8'h00, 8'h72};
        txn("rd_after_rst", 1'b0, 32'h0000_1008, 32'h0, base + 1);
        chk("rd_after_rst_data", last_res, 32'h0403_0201);
        chk("rd_after_rst_pulses", res_cnt, base + 1);

        exp_tx = '{8'h61, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("wr_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        exp_tx = '{8'h77, 8'hAA, 8'h55, 8'hAA, 8'h55};
        txn("wr_wrap", 1'b1, 32'h0000_0000, 32'h55AA_55AA, 0);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
